// File: rtl/lsu_ctrl.sv
// Load/store unit controller: byte/half/word accesses to a 1K-word data memory with registered read.
// Optional macro LSU_MISALIGN_TRAP_EN enables misalignment trapping through ERR (default: addresses are force-aligned).
module lsu_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic [31:0] rdata,
   output logic        misalign,
   output logic [9:0]  dm_addr,
   output logic [31:0] dm_din,
   output logic        dm_wr,
   input  logic [31:0] dm_dout
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] RD   = 3'd1;
   localparam logic [2:0] MRG  = 3'd2;
   localparam logic [2:0] WR   = 3'd3;
   localparam logic [2:0] DONE = 3'd4;
   localparam logic [2:0] ERR  = 3'd5;

   logic [2:0]  state_reg, state_next;
   logic        we_reg;
   logic [1:0]  size_reg;
   logic        sign_ext_reg;
   logic [11:0] addr_reg;
   logic [31:0] wdata_reg;
   logic [31:0] rdata_reg;

   logic [11:0] addr_eff;
   logic        mis_req;
   logic [3:0]  be;
   logic [31:0] wlane;
   logic [31:0] merged;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_val;
   logic        unused_addr_hi;

   assign unused_addr_hi = ^addr[31:12];

`ifdef LSU_MISALIGN_TRAP_EN
   assign mis_req  = (size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
   assign addr_eff = addr[11:0];
   assign misalign = (state_reg == ERR);
`else
   assign mis_req  = 1'b0;
   always_comb begin
      addr_eff = addr[11:0];
      if (size[1])
         addr_eff[1:0] = 2'b00;
      else if (size[0])
         addr_eff[0] = 1'b0;
   end
   assign misalign = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (req) begin
               if (mis_req)
                  state_next = ERR;
               else if (we && size[1])
                  state_next = WR;
               else
                  state_next = RD;
            end
         end
         RD:      state_next = we_reg ? MRG : DONE;
         MRG:     state_next = DONE;
         WR:      state_next = DONE;
         DONE:    state_next = IDLE;
         ERR:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         we_reg       <= 1'b0;
         size_reg     <= 2'b00;
         sign_ext_reg <= 1'b0;
         addr_reg     <= 12'd0;
         wdata_reg    <= 32'd0;
         rdata_reg    <= 32'd0;
      end else begin
         state_reg <= state_next;
         if (state_reg == IDLE && req) begin
            we_reg       <= we;
            size_reg     <= size;
            sign_ext_reg <= sign_ext;
            addr_reg     <= addr_eff;
            wdata_reg    <= wdata;
         end
         if (state_reg == RD && !we_reg)
            rdata_reg <= ld_val;
      end
   end

   // The word is already addressed in IDLE so its read data is present during RD,
   // letting rdata be registered at the RD->DONE edge.
   assign dm_addr = (state_reg == IDLE) ? addr[11:2] : addr_reg[11:2];
   assign dm_wr   = (state_reg == MRG) || (state_reg == WR);
   assign ready   = (state_reg == DONE) || (state_reg == ERR);
   assign rdata   = rdata_reg;

   always_comb begin
      if (size_reg[1])
         be = 4'b1111;
      else if (size_reg[0])
         be = addr_reg[1] ? 4'b1100 : 4'b0011;
      else
         be = 4'b0001 << addr_reg[1:0];
   end

   assign wlane = size_reg[1] ? wdata_reg :
                  size_reg[0] ? {2{wdata_reg[15:0]}} : {4{wdata_reg[7:0]}};

   // Word writes have all lanes enabled, so WR reuses the merge path unchanged.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign merged[8*gi +: 8] = be[gi] ? wlane[8*gi +: 8] : dm_dout[8*gi +: 8];
      end
   endgenerate

   assign dm_din = merged;

   assign ld_byte = dm_dout[{addr_reg[1:0], 3'b000} +: 8];
   assign ld_half = addr_reg[1] ? dm_dout[31:16] : dm_dout[15:0];

   always_comb begin
      if (size_reg[1])
         ld_val = dm_dout;
      else if (size_reg[0])
         ld_val = {{16{sign_ext_reg & ld_half[15]}}, ld_half};
      else
         ld_val = {{24{sign_ext_reg & ld_byte[7]}}, ld_byte};
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed testbench for lsu_ctrl: vector table of single accesses plus held-request and mid-access reset sequences.
// Builds with or without LSU_MISALIGN_TRAP_EN; the misaligned vectors follow the macro.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        sign_ext;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ready;
   logic [31:0] rdata;
   logic        misalign;
   logic [9:0]  dm_addr;
   logic [31:0] dm_din;
   logic        dm_wr;
   logic [31:0] dm_dout;

   logic        mem_init;
   logic [31:0] mem [0:1023];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lsu_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .we       (we),
      .size     (size),
      .sign_ext (sign_ext),
      .addr     (addr),
      .wdata    (wdata),
      .ready    (ready),
      .rdata    (rdata),
      .misalign (misalign),
      .dm_addr  (dm_addr),
      .dm_din   (dm_din),
      .dm_wr    (dm_wr),
      .dm_dout  (dm_dout)
   );

   // Data memory model with registered read
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
         mem[0] <= 32'h11223344;
         mem[5] <= 32'h8899AABB;
      end else begin
         if (dm_wr) mem[dm_addr] <= dm_din;
         dm_dout <= mem[dm_addr];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sext;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          lat;
      logic [31:0] rdata;
      logic        mis;
      int          nwr;
      int          wcyc;
      logic [9:0]  waddr;
      logic [31:0] din;
   } vec_t;

   vec_t vecs [14];

   task automatic run_txn(input vec_t v, output int lat, output logic [31:0] rd, output logic mis,
                          output int nwr, output int wcyc, output logic [9:0] wad,
                          output logic [31:0] wdin, output logic got, output logic after_rdy);
      @(negedge clk);
      req = 1'b1; we = v.we; size = v.size; sign_ext = v.sext; addr = v.addr; wdata = v.wdata;
      @(posedge clk); #1;
      req = 1'b0;
      lat = 0; rd = 32'd0; mis = 1'b0; nwr = 0; wcyc = 0; wad = 10'd0; wdin = 32'd0; got = 1'b0;
      for (int c = 1; c <= 8 && !got; c++) begin
         if (dm_wr) begin
            nwr++; wcyc = c; wad = dm_addr; wdin = dm_din;
         end
         if (ready) begin
            got = 1'b1; lat = c; rd = rdata; mis = misalign;
         end else begin
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;
      after_rdy = ready;
   endtask

   initial begin
      int          lat, nwr, wcyc;
      logic [31:0] rd, wdin;
      logic        mis, got, after_rdy, bad;
      logic [9:0]  wad;

      vecs[0]  = '{1'b0, 2'b00, 1'b1, 32'h016, 32'h0, 2, 32'hFFFFFF99, 1'b0, 0, 0, 10'd0, 32'h0};
      vecs[1]  = '{1'b0, 2'b01, 1'b0, 32'h014, 32'h0, 2, 32'h0000AABB, 1'b0, 0, 0, 10'd0, 32'h0};
      vecs[2]  = '{1'b0, 2'b00, 1'b1, 32'h014, 32'h0, 2, 32'hFFFFFFBB, 1'b0, 0, 0, 10'd0, 32'h0};
      vecs[3]  = '{1'b0, 2'b01, 1'b1, 32'h016, 32'h0, 2, 32'hFFFF8899, 1'b0, 0, 0, 10'd0, 32'h0};
      vecs[4]  = '{1'b0, 2'b10, 1'b1, 32'h014, 32'h0, 2, 32'h8899AABB, 1'b0, 0, 0, 10'd0, 32'h0};
      vecs[5]  = '{1'b0, 2'b00, 1'b0, 32'h017, 32'h0, 2, 32'h00000088, 1'b0, 0, 0, 10'd0, 32'h0};
      vecs[6]  = '{1'b1, 2'b00, 1'b0, 32'h015, 32'h000000CC, 3, 32'h0, 1'b0, 1, 2, 10'd5, 32'h8899CCBB};
      vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h014, 32'h0, 2, 32'h8899CCBB, 1'b0, 0, 0, 10'd0, 32'h0};
      vecs[8]  = '{1'b1, 2'b01, 1'b0, 32'h016, 32'hFFFF1234, 3, 32'h0, 1'b0, 1, 2, 10'd5, 32'h1234CCBB};
      vecs[9]  = '{1'b1, 2'b10, 1'b0, 32'h020, 32'h12345678, 2, 32'h0, 1'b0, 1, 1, 10'd8, 32'h12345678};
      vecs[10] = '{1'b0, 2'b11, 1'b0, 32'h020, 32'h0, 2, 32'h12345678, 1'b0, 0, 0, 10'd0, 32'h0};
      vecs[11] = '{1'b0, 2'b10, 1'b0, 32'hFFFFF014, 32'h0, 2, 32'h1234CCBB, 1'b0, 0, 0, 10'd0, 32'h0};
`ifdef LSU_MISALIGN_TRAP_EN
      vecs[12] = '{1'b1, 2'b01, 1'b0, 32'h003, 32'h0000BEEF, 1, 32'h0, 1'b1, 0, 0, 10'd0, 32'h0};
      vecs[13] = '{1'b0, 2'b01, 1'b0, 32'h001, 32'h0, 1, 32'h0, 1'b1, 0, 0, 10'd0, 32'h0};
`else
      vecs[12] = '{1'b1, 2'b01, 1'b0, 32'h003, 32'h0000BEEF, 3, 32'h0, 1'b0, 1, 2, 10'd0, 32'hBEEF3344};
      vecs[13] = '{1'b0, 2'b01, 1'b0, 32'h001, 32'h0, 2, 32'h00003344, 1'b0, 0, 0, 10'd0, 32'h0};
`endif

      rst_n = 1'b0; mem_init = 1'b1;
      req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0; addr = 32'd0; wdata = 32'd0;
      #3;
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_misalign", {31'd0, misalign}, 32'd0);
      check("rst_dm_wr", {31'd0, dm_wr}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      mem_init = 1'b0; rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         run_txn(vecs[i], lat, rd, mis, nwr, wcyc, wad, wdin, got, after_rdy);
         $display("txn %0d we=%0b size=%0d addr=%h lat=%0d rdata=%h mis=%0b writes=%0d",
                  i, vecs[i].we, vecs[i].size, vecs[i].addr, lat, rd, mis, nwr);
         check($sformatf("v%0d_ready_seen", i), {31'd0, got}, 32'd1);
         check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
         check($sformatf("v%0d_misalign", i), {31'd0, mis}, {31'd0, vecs[i].mis});
         check($sformatf("v%0d_writes", i), 32'(nwr), 32'(vecs[i].nwr));
         check($sformatf("v%0d_ready_pulse", i), {31'd0, after_rdy}, 32'd0);
         if (!vecs[i].we && !vecs[i].mis)
            check($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
         if (vecs[i].nwr > 0) begin
            check($sformatf("v%0d_wr_cycle", i), 32'(wcyc), 32'(vecs[i].wcyc));
            check($sformatf("v%0d_wr_addr", i), {22'd0, wad}, {22'd0, vecs[i].waddr});
            check($sformatf("v%0d_wr_data", i), wdin, vecs[i].din);
         end
      end

      // Request held through DONE: second acceptance only from the next IDLE
      @(negedge clk);
      req = 1'b1; we = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 32'h020; wdata = 32'h12345678;
      @(posedge clk); #1;
      check("held_c1_wr", {31'd0, dm_wr}, 32'd1);
      check("held_c1_addr", {22'd0, dm_addr}, 32'd8);
      check("held_c1_din", dm_din, 32'h12345678);
      @(posedge clk); #1;
      check("held_c2_ready", {31'd0, ready}, 32'd1);
      check("held_c2_wr", {31'd0, dm_wr}, 32'd0);
      wdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      check("held_c3_idle_ready", {31'd0, ready}, 32'd0);
      check("held_c3_idle_wr", {31'd0, dm_wr}, 32'd0);
      @(posedge clk); #1;
      check("held_c4_wr", {31'd0, dm_wr}, 32'd1);
      check("held_c4_din", dm_din, 32'hCAFEF00D);
      req = 1'b0;
      @(posedge clk); #1;
      check("held_c5_ready", {31'd0, ready}, 32'd1);
      @(posedge clk); #1;
      $display("txn held_req word store addr=%h twice", 32'h020);

      // Reset pulse during MRG aborts the store
      @(negedge clk);
      req = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h015; wdata = 32'h00000077;
      @(posedge clk); #1;
      req = 1'b0;
      @(posedge clk); #1;
      check("mrg_wr_before_reset", {31'd0, dm_wr}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("reset_dm_wr_drop", {31'd0, dm_wr}, 32'd0);
      check("reset_ready_low", {31'd0, ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         if (dm_wr || ready) bad = 1'b1;
      end
      check("post_reset_quiet", {31'd0, bad}, 32'd0);
      check("post_reset_mem5", mem[5], 32'h1234CCBB);
      $display("txn reset_during_mrg addr=%h", 32'h015);

      vecs[0] = '{1'b0, 2'b10, 1'b0, 32'h014, 32'h0, 2, 32'h1234CCBB, 1'b0, 0, 0, 10'd0, 32'h0};
      run_txn(vecs[0], lat, rd, mis, nwr, wcyc, wad, wdin, got, after_rdy);
      $display("txn post_reset load addr=%h lat=%0d rdata=%h", vecs[0].addr, lat, rd);
      check("post_reset_latency", 32'(lat), 32'd2);
      check("post_reset_rdata", rd, 32'h1234CCBB);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
